// File: rtl/iir_pkg.sv
// Shared types and constants for the first-order IIR filter and its inverse.
package iir_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic signed [8:0] COEFF_DEFAULT = -9'sd126;

    localparam int Q17_MAX = 127;
    localparam int Q17_MIN = -128;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t MULT  = 2'd1;
    localparam state_t ROUND = 2'd2;
    localparam state_t SUB   = 2'd3;

endpackage

// File: rtl/q17_sat.sv
// Clamp an N-bit signed value into Q1.7 range and flag when clipping occurred.
module q17_sat
    import iir_pkg::*;
#(
    parameter int unsigned IN_W = 10
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [7:0]      dout,
    output logic                   clip
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(Q17_MAX);
    localparam logic signed [IN_W-1:0] LO = IN_W'(Q17_MIN);

    always_comb begin
        dout = din[7:0];
        clip = 1'b0;
        if (din > HI) begin
            dout = 8'(Q17_MAX);
            clip = 1'b1;
        end else if (din < LO) begin
            dout = 8'(Q17_MIN);
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/iir_inverse_fir.sv
// Inverse of the first-order recursive filter: x[n] = y[n] - b0*y[n-1], Q1.7.
// Optional clip indicator sat_o enabled by IIR_INV_SAT_FLAG_EN.
module iir_inverse_fir
    import iir_pkg::*;
#(
    parameter logic signed [8:0] COEFF  = COEFF_DEFAULT,
    parameter int unsigned       DATA_W = iir_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] result_o,
    output logic              valid_o,
`ifdef IIR_INV_SAT_FLAG_EN
    output logic              sat_o,
`endif
    output logic              busy_o
);

    localparam int unsigned P_W    = DATA_W + 10;
    localparam int unsigned T_W    = P_W - 7;
    localparam int unsigned DIFF_W = DATA_W + 2;

    state_t                    state_r, state_n;
    logic signed [DATA_W-1:0]  d_r, d_n;
    logic signed [DATA_W-1:0]  y_prev_r, y_prev_n;
    logic signed [P_W-1:0]     p_r, p_n;
    logic signed [DATA_W-1:0]  t_r, t_n;
    logic signed [DIFF_W-1:0]  diff_r, diff_n;
    logic                      ovf_r, ovf_n;
    logic [DATA_W-1:0]         result_n;
    logic                      valid_n, busy_n;

    logic signed [P_W-1:0]     p_rnd;
    logic signed [T_W-1:0]     t_wide;
    logic [7:0]                t_sat, d_sat;
    logic                      t_clip, d_clip;

    // Round half up: add half an LSB of the output scale, then arithmetic shift.
    assign p_rnd  = p_r + P_W'(64);
    assign t_wide = p_rnd[P_W-1:7];

    q17_sat #(.IN_W(T_W)) u_t_sat (
        .din  (t_wide),
        .dout (t_sat),
        .clip (t_clip)
    );

    q17_sat #(.IN_W(DIFF_W)) u_d_sat (
        .din  (diff_r),
        .dout (d_sat),
        .clip (d_clip)
    );

`ifdef IIR_INV_SAT_FLAG_EN
    logic t_clip_r, t_clip_n;
    logic sat_n;
`else
    logic unused_clip;
    assign unused_clip = t_clip ^ d_clip;
`endif

    always_comb begin
        state_n  = state_r;
        d_n      = d_r;
        y_prev_n = y_prev_r;
        p_n      = p_r;
        t_n      = t_r;
        diff_n   = diff_r;
        ovf_n    = ovf_r;
        result_n = result_o;
        valid_n  = valid_o;
        busy_n   = busy_o;
`ifdef IIR_INV_SAT_FLAG_EN
        t_clip_n = t_clip_r;
        sat_n    = sat_o;
`endif
        case (state_r)
            IDLE: begin
                if (en_i) begin
                    d_n     = d_in;
                    p_n     = P_W'(y_prev_r) * P_W'(COEFF);
                    valid_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = MULT;
`ifdef IIR_INV_SAT_FLAG_EN
                    sat_n   = 1'b0;
`endif
                end
            end
            MULT: begin
                t_n     = t_sat;
                state_n = ROUND;
`ifdef IIR_INV_SAT_FLAG_EN
                t_clip_n = t_clip;
`endif
            end
            ROUND: begin
                diff_n  = DIFF_W'(d_r) - DIFF_W'(t_r);
                ovf_n   = d_r[DATA_W-1] ^ t_r[DATA_W-1];
                state_n = SUB;
            end
            SUB: begin
                // Same-sign operands cannot leave the Q1.7 range.
                result_n = ovf_r ? d_sat : diff_r[DATA_W-1:0];
                valid_n  = 1'b1;
                busy_n   = 1'b0;
                y_prev_n = d_r;
                state_n  = IDLE;
`ifdef IIR_INV_SAT_FLAG_EN
                sat_n    = t_clip_r | (ovf_r & d_clip);
`endif
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            d_r      <= '0;
            y_prev_r <= '0;
            p_r      <= '0;
            t_r      <= '0;
            diff_r   <= '0;
            ovf_r    <= 1'b0;
            result_o <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
`ifdef IIR_INV_SAT_FLAG_EN
            t_clip_r <= 1'b0;
            sat_o    <= 1'b0;
`endif
        end else begin
            state_r  <= state_n;
            d_r      <= d_n;
            y_prev_r <= y_prev_n;
            p_r      <= p_n;
            t_r      <= t_n;
            diff_r   <= diff_n;
            ovf_r    <= ovf_n;
            result_o <= result_n;
            valid_o  <= valid_n;
            busy_o   <= busy_n;
`ifdef IIR_INV_SAT_FLAG_EN
            t_clip_r <= t_clip_n;
            sat_o    <= sat_n;
`endif
        end
    end

endmodule

// File: tb/tb_iir_inverse_fir.sv
// Directed bench for iir_inverse_fir; checks sat_o when IIR_INV_SAT_FLAG_EN is defined.
module tb_iir_inverse_fir;

    localparam int COEFF_V = -126;

    logic       clk;
    logic       rst_i;
    logic       en_i;
    logic [7:0] d_in;
    logic [7:0] result_o;
    logic       valid_o;
    logic       busy_o;
`ifdef IIR_INV_SAT_FLAG_EN
    logic       sat_o;
`endif

    int tests;
    int fails;

    iir_inverse_fir dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .d_in     (d_in),
        .result_o (result_o),
        .valid_o  (valid_o),
`ifdef IIR_INV_SAT_FLAG_EN
        .sat_o    (sat_o),
`endif
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept edge plus three processing edges.
    task automatic send(input logic [7:0] d);
        en_i = 1'b1;
        d_in = d;
        tick();
        en_i = 1'b0;
        d_in = 8'h5A;
        tick();
        tick();
        tick();
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic test_reset;
        en_i = 1'b0;
        d_in = 8'h00;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tests++;
        if (result_o !== 8'h00 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset: result=%h valid=%b busy=%b, want 00/0/0", result_o, valid_o, busy_o);
        end
`ifdef IIR_INV_SAT_FLAG_EN
        tests++;
        if (sat_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_sat: sat=%b, want 0", sat_o);
        end
`endif
    endtask

    task automatic test_latency;
        logic [2:0] busy_seen;
        logic [2:0] valid_seen;
        en_i = 1'b1;
        d_in = 8'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            en_i = 1'b0;
            d_in = 8'h11;
            busy_seen[i]  = busy_o;
            valid_seen[i] = valid_o;
        end
        tests++;
        if (busy_seen !== 3'b111 || valid_seen !== 3'b000) begin
            fails++;
            $display("FAIL latency_busy: busy=%b valid=%b over N..N+2, want 111/000", busy_seen, valid_seen);
        end
        tick();
        tests++;
        if (busy_o !== 1'b0 || valid_o !== 1'b1 || result_o !== 8'h40) begin
            fails++;
            $display("FAIL latency_result: busy=%b valid=%b result=%h, want 0/1/40", busy_o, valid_o, result_o);
        end
        tick();
        tests++;
        if (valid_o !== 1'b1 || result_o !== 8'h40) begin
            fails++;
            $display("FAIL valid_hold: valid=%b result=%h, want 1/40", valid_o, result_o);
        end
    endtask

    // Directed chain continuing from y_prev=0x40 left by test_latency.
    task automatic test_saturation;
        logic [7:0] din_v [5];
        logic [7:0] exp_v [5];
        logic       sat_v [5];
        din_v = '{8'h40, 8'h7F, 8'h7F, 8'h80, 8'h80};
        exp_v = '{8'h7F, 8'h7F, 8'h7F, 8'hFD, 8'h80};
        sat_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send(din_v[i]);
            tests++;
            if (result_o !== exp_v[i] || valid_o !== 1'b1) begin
                fails++;
                $display("FAIL sat_vec%0d: result=%h valid=%b, want %h/1", i, result_o, valid_o, exp_v[i]);
            end
`ifdef IIR_INV_SAT_FLAG_EN
            tests++;
            if (sat_o !== sat_v[i]) begin
                fails++;
                $display("FAIL sat_flag%0d: sat=%b, want %b", i, sat_o, sat_v[i]);
            end
`else
            if (sat_v[i] === 1'bx) $display("unexpected sat table entry");
`endif
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] din_v [3];
        logic [7:0] exp_v [3];
        din_v = '{8'h10, 8'h20, 8'h30};
        exp_v = '{8'h10, 8'h30, 8'h4F};
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = din_v[i];
            tick();
            d_in = 8'h7F;
            tests++;
            if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
                fails++;
                $display("FAIL b2b_accept%0d: busy=%b valid=%b, want 1/0", i, busy_o, valid_o);
            end
            tick();
            tick();
            tick();
            tests++;
            if (busy_o !== 1'b0 || valid_o !== 1'b1 || result_o !== exp_v[i]) begin
                fails++;
                $display("FAIL b2b_result%0d: busy=%b valid=%b result=%h, want 0/1/%h",
                         i, busy_o, valid_o, result_o, exp_v[i]);
            end
        end
        en_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        send(8'h40);
        en_i = 1'b1;
        d_in = 8'h50;
        tick();
        en_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b busy=%b, want 0/0", valid_o, busy_o);
        end
        tick();
        tick();
        tests++;
        if (valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_novalid: valid=%b, want 0", valid_o);
        end
        send(8'h20);
        tests++;
        if (result_o !== 8'h20 || valid_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_history: result=%h valid=%b, want 20/1", result_o, valid_o);
        end
    endtask

    // Forward filter model feeding the DUT; inputs steered to keep y unsaturated.
    task automatic test_chain;
        int yp;
        int x;
        int t;
        int y;
        int got;
        int err_cnt;
        int sat_cnt;
        do_reset();
        yp = 0;
        err_cnt = 0;
        sat_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            x = int'($urandom_range(64, 0)) - 32;
            t = clamp8((yp * COEFF_V + 64) >>> 7);
            y = clamp8(x + t);
            if (y > 96 || y < -96) begin
                x = -x;
                y = clamp8(x + t);
            end
            send(8'(y));
            got = int'($signed(result_o));
            if (got - x > 2 || x - got > 2 || valid_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL chain%0d: recovered=%0d valid=%b, want %0d (+/-2)/1", i, got, valid_o, x);
            end
`ifdef IIR_INV_SAT_FLAG_EN
            if (sat_o !== 1'b0) sat_cnt++;
`endif
            yp = y;
        end
        tests++;
        if (err_cnt != 0) begin
            fails++;
            $display("FAIL chain_total: errors=%0d, want 0", err_cnt);
        end
`ifdef IIR_INV_SAT_FLAG_EN
        tests++;
        if (sat_cnt != 0) begin
            fails++;
            $display("FAIL chain_sat: sat asserted %0d times, want 0", sat_cnt);
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_i = 1'b1;
        en_i  = 1'b0;
        d_in  = 8'h00;
        test_reset();
        test_latency();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_chain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
